// File: rtl/oled_pkg.sv
// Shared OLED screen-selection constants and helpers.
// The screen multiplexer and the screen renderers use the same definitions.
package oled_pkg;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_MENU = 4'd0;
  localparam int NUM_SCREENS_MAX = 15;

  // The FSM is ARMED exactly while a screen request is pending.
  typedef enum logic {
    SEQ_IDLE,
    SEQ_ARMED
  } seq_state_e;

  // Winning action after U > C > L > R arbitration.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_U,
    ACT_C,
    ACT_L,
    ACT_R
  } action_e;

  // Cursor step right, wrapping last -> 1.
  function automatic logic [ST_W-1:0] wrap_inc(input logic [ST_W-1:0] v,
                                               input logic [ST_W-1:0] last);
    return (v >= last) ? 4'd1 : v + 4'd1;
  endfunction

  // Cursor step left, wrapping 1 -> last.
  function automatic logic [ST_W-1:0] wrap_dec(input logic [ST_W-1:0] v,
                                               input logic [ST_W-1:0] last);
    return (v <= 4'd1) ? last : v - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, debounce counter,
// and a one-cycle pulse on each qualified rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // Synchronise, count stable disagreement cycles, then flip the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          // Only the rising edge of the debounced level is a press.
          press_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/oled_state_sequencer.sv
// Menu / screen-select sequencer for the OLED path. Debounces the four
// navigation buttons, moves the menu cursor, and latches screen requests
// that are committed to machine_state only on frame_begin.
module oled_state_sequencer
  import oled_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int NUM_SCREENS     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_c,
  input  logic            btn_l,
  input  logic            btn_r,
  input  logic            btn_u,
  input  logic            frame_begin,
  output logic [ST_W-1:0] machine_state,
  output logic [ST_W-1:0] menu_cursor,
  output logic            state_changed
);

  localparam logic [ST_W-1:0] LAST_SCREEN = ST_W'(NUM_SCREENS);

  // Bit order: [3]=U, [2]=C, [1]=L, [0]=R (descending priority).
  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_u, btn_c, btn_l, btn_r};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_i      (btn_raw[gi]),
        .press_pulse(press[gi])
      );
    end
  endgenerate

  seq_state_e      fsm_q;
  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] cursor_q;
  logic [ST_W-1:0] pending_q;
  logic            changed_q;

  action_e         act;
  logic            req_valid;
  logic [ST_W-1:0] req_state;
  logic [ST_W-1:0] cursor_d;
  logic            in_menu;

  assign in_menu = (state_q == ST_MENU);

  // Pick one action per cycle and translate it into a request or cursor move.
  always_comb begin
    act       = ACT_NONE;
    req_valid = 1'b0;
    req_state = ST_MENU;
    cursor_d  = cursor_q;

    if (press[3])      act = ACT_U;
    else if (press[2]) act = ACT_C;
    else if (press[1]) act = ACT_L;
    else if (press[0]) act = ACT_R;

    case (act)
      ACT_U: if (!in_menu) req_valid = 1'b1;
      ACT_C: begin
        if (in_menu) begin
          req_valid = 1'b1;
          req_state = cursor_q;
        end
      end
      ACT_L:   if (in_menu) cursor_d = wrap_dec(cursor_q, LAST_SCREEN);
      ACT_R:   if (in_menu) cursor_d = wrap_inc(cursor_q, LAST_SCREEN);
      default: ;
    endcase
  end

  // Pending/commit FSM: requests arm it, frame_begin commits the older pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= SEQ_IDLE;
      state_q   <= ST_MENU;
      cursor_q  <= 4'd1;
      pending_q <= ST_MENU;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      cursor_q  <= cursor_d;
      case (fsm_q)
        SEQ_IDLE: begin
          if (req_valid) begin
            pending_q <= req_state;
            fsm_q     <= SEQ_ARMED;
          end
        end
        SEQ_ARMED: begin
          if (frame_begin) begin
            state_q   <= pending_q;
            changed_q <= (pending_q != state_q);
          end
          // A request coinciding with the commit stays pending for the next frame.
          if (req_valid) begin
            pending_q <= req_state;
            fsm_q     <= SEQ_ARMED;
          end else if (frame_begin) begin
            fsm_q <= SEQ_IDLE;
          end
        end
        default: fsm_q <= SEQ_IDLE;
      endcase
    end
  end

  assign machine_state = state_q;
  assign menu_cursor   = cursor_q;
  assign state_changed = changed_q;

endmodule

// File: doc/oled_state_sequencer.md
# oled_state_sequencer

Generates the 4-bit `machine_state` that selects which screen's pixel stream reaches the OLED. It sits directly upstream of the OLED screen multiplexer. It debounces the four navigation buttons and runs the menu and screen-select state machine. Screen changes take effect only on the OLED driver's `frame_begin` pulse, so no frame is drawn from two different screens.

## Interface
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable cycles a synchronised button must hold before its debounced level changes (2 ms at 100 MHz).
- `NUM_SCREENS`, default 8: selectable screens, numbered 1..NUM_SCREENS; state 0 is the menu.
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_c`, `btn_l`, `btn_r`, `btn_u` in 1 each: raw, asynchronous push-buttons, active-high.
- `frame_begin` in 1: one-cycle pulse from the OLED driver at the start of each frame.
- `machine_state` out 4: current screen. 0 is the menu; 1..NUM_SCREENS are screens.
- `menu_cursor` out 4: highlighted menu entry, 1..NUM_SCREENS. It is consumed by the menu renderer.
- `state_changed` out 1: one-cycle pulse on the cycle `machine_state` takes a new value.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synced input differs from the debounced level.
  - It clears to 0 whenever the two are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press pulse is asserted for exactly the cycle in which the debounced level rises. Release produces no pulse.
- **Action arbitration:** at most one action is taken per cycle. Priority is U > C > L > R. Lower-priority pulses in the same cycle are dropped.
- **Actions in the menu** (`machine_state`==0):
  - L: cursor decrements and wraps 1 -> NUM_SCREENS.
  - R: cursor increments and wraps NUM_SCREENS -> 1.
  - C: request = cursor.
  - U: ignored.
- **Actions on a screen** (`machine_state`!=0):
  - U: request = 0.
  - C, L, R: ignored.
  - `menu_cursor` holds its value, so returning to the menu restores the last highlight.
- **Pending request:** a request loads `pending_state` and sets `pending_valid`. A newer request before commit overwrites the older one (last wins).
- **Commit:** on a cycle with `frame_begin`=1 and `pending_valid`=1:
  - `machine_state` <= `pending_state` and `pending_valid` clears.
  - `state_changed` pulses only if the new value differs from the old one.
- **Request and frame_begin in the same cycle:** the commit uses the `pending_state` registered before that cycle. The new request becomes pending for the next `frame_begin`.
- **FSM:** two states.
  - IDLE -> ARMED on a request.
  - ARMED -> IDLE on `frame_begin`.
  - ARMED -> ARMED on a further request, overwriting `pending_state`.
- **Reset values:**
  - Outputs: `machine_state`=0, `menu_cursor`=1, `state_changed`=0.
  - Internal: `pending_valid`=0, debounced levels 0, counters 0, synchronisers 0.
- **Reset mid-operation:** any pending request and any partial debounce count are discarded. A button held through reset release must re-qualify for DEBOUNCE_CYCLES cycles before it produces a press.

## Timing
- Raw press to press pulse: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 cycles, with the input held stable.
- Press pulse to the `pending_state`/`menu_cursor` update: 1 cycle (registered).
- `frame_begin` to the new `machine_state`: 1 cycle. `state_changed` is asserted in that same cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- Worst-case request-to-display latency is one frame period plus 1 cycle.

## Structure
- **Shared package `oled_pkg`:** `ST_MENU`=4'd0, the state width (4), and `NUM_SCREENS_MAX`=15. The OLED screen multiplexer and the screen renderers import the same constants.
- **One sub-module, `btn_debounce`:** a synchroniser plus the debounce counter, with `press_pulse` as output. It is instantiated four times.
- The arbitration, cursor and pending/commit FSM live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_SCREENS=8.
- Reset, then idle for 50 cycles -> `machine_state`=0, `menu_cursor`=1, `state_changed` never asserted.
- `btn_r` held 10 cycles, pressed 8 times -> cursor steps 2,3,...,8,1 (wrap). `btn_l` pressed once from 1 -> 8.
- `btn_c` held for only 3 cycles (bounce) -> no press, no request. Held for 7 cycles -> one press, exactly one pulse.
- Cursor=7, `btn_c` press, `frame_begin` 20 cycles later -> `machine_state`=7 one cycle after `frame_begin`, one `state_changed` pulse. `btn_u` press, next `frame_begin` -> `machine_state`=0 and cursor still 7.
- In the menu, `btn_u` and `btn_r` pulses in the same cycle -> U wins but is ignored in the menu, so the cursor is unchanged. On screen 3, `btn_u` and `btn_c` in the same cycle -> request 0.
- Request 5, then request 2 before `frame_begin` -> commit to 2. A request arriving in the same cycle as `frame_begin` commits only at the following `frame_begin`. `rst_n` asserted while ARMED -> `machine_state`=0 and nothing commits afterwards.
